// File: rtl/hazard_sel_ctrl.sv
// hazard_sel_ctrl: pipeline hazard controller for the 5-stage sync-fetch CPU.
// Drives the 2-bit selects of every pipeline-register input mux:
//   00 = advance, 01 = hold (feedback), 10 = bubble (reset value), 11 unused.
// Handles load-use stalls, taken-branch flushes and data-memory wait holds.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush perf counters;
// without it both counter outputs are tied to zero.
module hazard_sel_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic [1:0]            pc_sel,
  output logic [1:0]            if_id_sel,
  output logic [1:0]            id_ex_sel,
  output logic [1:0]            ex_mem_sel,
  output logic [1:0]            mem_wb_sel,
  output logic                  mem_timeout,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
);

  localparam logic [1:0] SEL_ADV  = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_BUB  = 2'b10;

  // Flush count holds at most FLUSH_CYCLES-1; watchdog holds at most MEM_WAIT_MAX.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WD_W = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [FC_W-1:0] flush_q, flush_nxt;
  logic [WD_W-1:0] wd_q, wd_nxt;
  logic            timeout_q;
  logic            load_use;

  // Load in EX writes a register the ID instruction actually reads (x0 never hazards).
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Next-state and Mealy select decode; priority mem_busy > branch > load-use.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    flush_nxt  = flush_q;
    pc_sel     = SEL_ADV;
    if_id_sel  = SEL_ADV;
    id_ex_sel  = SEL_ADV;
    ex_mem_sel = SEL_ADV;
    mem_wb_sel = SEL_ADV;

    if (mem_busy) begin
      // Freeze everything up to EX/MEM; MEM/WB takes a bubble. Flush count frozen.
      pc_sel     = SEL_HOLD;
      if_id_sel  = SEL_HOLD;
      id_ex_sel  = SEL_HOLD;
      ex_mem_sel = SEL_HOLD;
      mem_wb_sel = SEL_BUB;
      if (state == RUN) next_state = MEM_WAIT;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_sel = SEL_BUB;
            id_ex_sel = SEL_BUB;
            if (FLUSH_CYCLES > 1) begin
              flush_nxt  = FC_W'(FLUSH_CYCLES - 1);
              next_state = FLUSH;
            end
          end else if (load_use) begin
            pc_sel    = SEL_HOLD;
            if_id_sel = SEL_HOLD;
            id_ex_sel = SEL_BUB;
          end
        end
        FLUSH: begin
          // Extra bubbles cover the synchronous I-mem returning wrong-path words.
          if_id_sel = SEL_BUB;
          flush_nxt = flush_q - FC_W'(1);
          if (flush_q <= FC_W'(1)) next_state = RUN;
        end
        MEM_WAIT: begin
          // Memory ready: everything advances; a held branch is seen again in RUN.
          next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end

    // While reset is asserted every pipeline register loads its reset value.
    if (reset) begin
      pc_sel     = SEL_BUB;
      if_id_sel  = SEL_BUB;
      id_ex_sel  = SEL_BUB;
      ex_mem_sel = SEL_BUB;
      mem_wb_sel = SEL_BUB;
    end
  end

  // Watchdog counts consecutive busy cycles, saturating; cleared when memory is ready.
  always_comb begin
    wd_nxt = '0;
    if (mem_busy) wd_nxt = (wd_q == WD_W'(MEM_WAIT_MAX)) ? wd_q : wd_q + WD_W'(1);
  end

  // State, flush count, watchdog and sticky timeout flag.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      flush_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= next_state;
      flush_q   <= flush_nxt;
      wd_q      <= wd_nxt;
      timeout_q <= timeout_q | (wd_nxt == WD_W'(MEM_WAIT_MAX));
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic any_hold;
  logic flush_evt;

  assign any_hold  = (pc_sel == SEL_HOLD) || (if_id_sel == SEL_HOLD) ||
                     (id_ex_sel == SEL_HOLD) || (ex_mem_sel == SEL_HOLD) ||
                     (mem_wb_sel == SEL_HOLD);
  assign flush_evt = (state == RUN) && !mem_busy && ex_branch_taken;

  // Saturating perf counters: hold cycles and RUN-state taken branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (any_hold && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_evt && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sel_ctrl.sv
// Self-checking bench for hazard_sel_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_sel_ctrl;

  localparam int REG_ADDR_W   = 5;
  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_WAIT_MAX = 15;

  localparam logic [9:0] S_RESET = 10'b10_10_10_10_10;
  localparam logic [9:0] S_RUN   = 10'b00_00_00_00_00;
  localparam logic [9:0] S_MEMW  = 10'b01_01_01_01_10;
  localparam logic [9:0] S_BR    = 10'b00_10_10_00_00;
  localparam logic [9:0] S_FL    = 10'b00_10_00_00_00;
  localparam logic [9:0] S_LU    = 10'b01_01_10_00_00;

  logic                  clk;
  logic                  reset;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic                  id_rs1_used, id_rs2_used;
  logic                  ex_mem_read, ex_branch_taken, mem_busy;
  logic [1:0]            pc_sel, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel;
  logic                  mem_timeout;
  logic [15:0]           stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_sel_ctrl #(
    .REG_ADDR_W  (REG_ADDR_W),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .pc_sel         (pc_sel),
    .if_id_sel      (if_id_sel),
    .id_ex_sel      (id_ex_sel),
    .ex_mem_sel     (ex_mem_sel),
    .mem_wb_sel     (mem_wb_sel),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_sel();
    return {pc_sel, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel};
  endfunction

  // ---------------- behavioural model ----------------
  int bub_left  = 0;   // IF/ID bubbles still owed after a taken branch
  bit in_wait   = 0;   // memory stall seen outside a flush; next ready cycle just advances
  int busy_run  = 0;   // consecutive busy cycles so far
  bit m_timeout = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  function automatic bit m_load_use();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  endfunction

  function automatic logic [9:0] exp_sel();
    if (reset)           return S_RESET;
    if (mem_busy)        return S_MEMW;
    if (bub_left > 0)    return S_FL;
    if (in_wait)         return S_RUN;
    if (ex_branch_taken) return S_BR;
    if (m_load_use())    return S_LU;
    return S_RUN;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bub_left = 0; in_wait = 0; busy_run = 0;
      m_timeout = 0; m_stall = 0; m_flush = 0;
    end else begin
      logic [9:0] s;
      bit         held;
      s = exp_sel();
      held = 0;
      for (int i = 0; i < 5; i++) if (s[2*i +: 2] == 2'b01) held = 1;
      if (held && m_stall < 65535) m_stall++;
      if (mem_busy) begin
        if (bub_left == 0) in_wait = 1;
        if (busy_run < 1000) busy_run++;
      end else begin
        busy_run = 0;
        if (bub_left > 0)         bub_left--;
        else if (in_wait)         in_wait = 0;
        else if (ex_branch_taken) begin
          bub_left = FLUSH_CYCLES - 1;
          if (m_flush < 65535) m_flush++;
        end
      end
      if (busy_run >= MEM_WAIT_MAX) m_timeout = 1;
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("sel", {22'd0, dut_sel()}, {22'd0, exp_sel()});
    check("timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
    check("flush_cnt", {16'd0, flush_cnt}, m_flush);
`else
    check("perf_tied", {stall_cnt, flush_cnt}, 32'd0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0;
  endtask

  int burst = 0;

  initial begin
    reset = 1;
    idle();
    repeat (3) @(posedge clk);
    #3;
    check("rst_sel", {22'd0, dut_sel()}, {22'd0, S_RESET});
    check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    go(); reset = 0; #2;
    check("idle_sel", {22'd0, dut_sel()}, {22'd0, S_RUN});

    // load-use on rs2
    go(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1; #2;
    check("lu_sel", {22'd0, dut_sel()}, {22'd0, S_LU});
    go(); idle(); #2;
    check("lu_after", {22'd0, dut_sel()}, {22'd0, S_RUN});
    // ex_rd = x0 never hazards
    go(); ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_rs2_used = 1; #2;
    check("lu_x0", {22'd0, dut_sel()}, {22'd0, S_RUN});
    go(); idle();

    // taken branch
    go(); ex_branch_taken = 1; #2;
    check("br_c0", {22'd0, dut_sel()}, {22'd0, S_BR});
    go(); ex_branch_taken = 0; #2;
    check("br_c1", {22'd0, dut_sel()}, {22'd0, S_FL});
    go(); #2;
    check("br_c2", {22'd0, dut_sel()}, {22'd0, S_RUN});
`ifdef HAZARD_PERF_CNT_EN
    check("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
`endif

    // memory wait with branch held in EX
    for (int k = 0; k < 4; k++) begin
      go(); mem_busy = 1; ex_branch_taken = 1; #2;
      check("mw_sel", {22'd0, dut_sel()}, {22'd0, S_MEMW});
    end
    go(); mem_busy = 0;
    go(); #2;
    check("mw_br_resume", {22'd0, dut_sel()}, {22'd0, S_BR});
`ifdef HAZARD_PERF_CNT_EN
    check("mw_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
    go(); ex_branch_taken = 0;
    go(); idle();

    // watchdog timeout
    for (int k = 1; k <= 20; k++) begin
      go(); mem_busy = 1; #2;
      if (k == 1)  check("wd_early", {31'd0, mem_timeout}, 32'd0);
      if (k == 17) check("wd_set", {31'd0, mem_timeout}, 32'd1);
    end
    go(); mem_busy = 0; #2;
    check("wd_sticky0", {31'd0, mem_timeout}, 32'd1);
    go(); #2;
    check("wd_sticky1", {31'd0, mem_timeout}, 32'd1);

    // reset mid-flush
    go(); ex_branch_taken = 1;
    go(); ex_branch_taken = 0; #2;
    reset = 1; #1;
    check("rst_async_sel", {22'd0, dut_sel()}, {22'd0, S_RESET});
    check("rst_async_to", {31'd0, mem_timeout}, 32'd0);
    go(); reset = 0; #2;
    check("rst_no_flush", {22'd0, dut_sel()}, {22'd0, S_RUN});
    go(); #2;
    check("rst_no_flush2", {22'd0, dut_sel()}, {22'd0, S_RUN});

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      go();
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      id_rs1 = REG_ADDR_W'($urandom_range(0, 3));
      id_rs2 = REG_ADDR_W'($urandom_range(0, 3));
      ex_rd  = REG_ADDR_W'($urandom_range(0, 3));
      id_rs1_used     = 1'($urandom_range(0, 1));
      id_rs2_used     = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      if (burst > 0) begin
        mem_busy = 1; burst--;
      end else if ($urandom_range(0, 29) == 0) begin
        mem_busy = 1; burst = $urandom_range(0, 19);
      end else begin
        mem_busy = 0;
      end
    end
    go(); idle(); reset = 0;
    go();
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
